// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
//   Shared definitions for the data-memory path: sign_mask access codes,
//   the memory-mapped LED address, the store-buffer FSM state encoding and
//   the layout of one buffered store entry.
//   No ports (package).
package store_buffer_pkg;

  // Access size / sign codes carried on sign_mask. The store buffer only
  // passes them through; data_mem interprets them.
  localparam logic [3:0] SM_BYTE       = 4'b0000;
  localparam logic [3:0] SM_HALF       = 4'b0001;
  localparam logic [3:0] SM_WORD       = 4'b0010;
  localparam int         SM_SIGNED_BIT = 2;
  localparam logic [3:0] SM_SIGNED     = 4'b0100;

  // Memory-mapped LED register inside data_mem.
  localparam logic [31:0] LED_ADDR = 32'h0000_2000;

  typedef enum logic [1:0] {
    SB_DRAIN      = 2'd0,
    SB_LOAD_ISSUE = 2'd1,
    SB_LOAD_WAIT  = 2'd2
  } sb_state_e;

  // One buffered store: {addr, data, sign_mask} = 68 bits.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sign_mask;
  } sb_entry_t;

  localparam int ENTRY_W = $bits(sb_entry_t);

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if
//   Memory request bus as presented by data_mem. The same bus is used on
//   the core side of the store buffer and on the data_mem side.
//   Signals:
//     addr        byte address
//     write_data  store data
//     memwrite    store request
//     memread     load request
//     sign_mask   access size/sign code
//     read_data   load result (slave -> master)
//     stall       slave is busy, master must hold its request (slave -> master)
//   Modports:
//     master  drives the request, receives read_data/stall
//     slave   receives the request, drives read_data/stall
interface store_buffer_if;

  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        stall;

  modport master (
    output addr, write_data, memwrite, memread, sign_mask,
    input  read_data, stall
  );

  modport slave (
    input  addr, write_data, memwrite, memread, sign_mask,
    output read_data, stall
  );

endinterface

// File: rtl/sb_fifo.sv
// sb_fifo
//   Synchronous FIFO holding buffered store entries. Reads are
//   fall-through: rdata always shows the head entry.
//   Ports:
//     clk, reset  clock, asynchronous active-high reset
//     push        write wdata at the tail (accepted when not full, or when
//                 full and a pop happens in the same cycle)
//     pop         drop the head entry (ignored when empty)
//     wdata       entry to push
//     rdata       head entry
//     full/empty  occupancy flags
//     count       number of valid entries, 0..DEPTH
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Occupancy comes from count alone, so a full FIFO never looks empty
  // even though both pointers are equal.
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = storage[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
//   Sits between the core's memory stage and data_mem. Stores are queued
//   in a small FIFO and drained to data_mem one per cycle while data_mem is
//   not stalling. Loads wait until every older store has been written, then
//   go to data_mem directly (no forwarding from the buffer).
//   Ports:
//     clk, reset  clock, asynchronous active-high reset
//     cpu         slave side of the memory bus, facing the core; cpu.stall
//                 tells the core to hold its request
//     mem         master side of the memory bus, facing data_mem; mem.stall
//                 is data_mem's clk_stall; all mem request outputs are
//                 registered
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave  cpu,
  store_buffer_if.master mem
);

  sb_state_e      state;
  sb_state_e      state_next;
  logic           seen_stall;
  logic           seen_stall_next;
  logic           load_done;
  logic           load_done_next;
  logic           cpu_stall;

  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  logic [PTR_W:0] count;
  sb_entry_t      in_entry;
  sb_entry_t      head;

  logic [31:0]    mem_addr_q;
  logic [31:0]    mem_wdata_q;
  logic           mem_wr_q;
  logic           mem_rd_q;
  logic [3:0]     mem_sm_q;
  logic [31:0]    mem_addr_next;
  logic [31:0]    mem_wdata_next;
  logic           mem_wr_next;
  logic           mem_rd_next;
  logic [3:0]     mem_sm_next;

  assign in_entry      = {cpu.addr, cpu.write_data, cpu.sign_mask};
  assign cpu.stall     = cpu_stall;
  assign cpu.read_data = mem.read_data;
  assign mem.addr       = mem_addr_q;
  assign mem.write_data = mem_wdata_q;
  assign mem.memwrite   = mem_wr_q;
  assign mem.memread    = mem_rd_q;
  assign mem.sign_mask  = mem_sm_q;

  sb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // State, handshake flags and the registered data_mem request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SB_DRAIN;
      seen_stall  <= 1'b0;
      load_done   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_sm_q    <= '0;
    end else begin
      state       <= state_next;
      seen_stall  <= seen_stall_next;
      load_done   <= load_done_next;
      mem_addr_q  <= mem_addr_next;
      mem_wdata_q <= mem_wdata_next;
      mem_wr_q    <= mem_wr_next;
      mem_rd_q    <= mem_rd_next;
      mem_sm_q    <= mem_sm_next;
    end
  end

  // Next-state and outputs. load_done marks the single DRAIN cycle right
  // after a load completes: the core still holds memread then, and that
  // cycle must release it instead of issuing the load again.
  always_comb begin
    state_next      = state;
    seen_stall_next = seen_stall;
    load_done_next  = 1'b0;
    cpu_stall       = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    mem_addr_next   = mem_addr_q;
    mem_wdata_next  = mem_wdata_q;
    mem_wr_next     = 1'b0;
    mem_rd_next     = 1'b0;
    mem_sm_next     = mem_sm_q;

    case (state)
      SB_DRAIN: begin
        seen_stall_next = 1'b0;
        pop = !empty && !mem.stall;
        if (pop) begin
          mem_wr_next    = 1'b1;
          mem_addr_next  = head.addr;
          mem_wdata_next = head.data;
          mem_sm_next    = head.sign_mask;
        end
        // A store wins over a simultaneous (illegal) load request.
        if (cpu.memwrite) begin
          push      = !full || pop;
          cpu_stall = full && !pop;
        end else if (cpu.memread) begin
          if (!load_done) begin
            cpu_stall = 1'b1;
            // Issue only once no older store is queued or on the bus.
            if ((count == '0) && !mem_wr_q) begin
              mem_rd_next   = 1'b1;
              mem_addr_next = cpu.addr;
              mem_sm_next   = cpu.sign_mask;
              state_next    = SB_LOAD_ISSUE;
            end
          end
        end
      end

      SB_LOAD_ISSUE: begin
        cpu_stall = 1'b1;
        if (mem.stall) seen_stall_next = 1'b1;
        state_next = SB_LOAD_WAIT;
      end

      SB_LOAD_WAIT: begin
        cpu_stall = 1'b1;
        // read_data is valid on the first non-stalled cycle after data_mem
        // has raised clk_stall for this read.
        if (mem.stall) begin
          seen_stall_next = 1'b1;
        end else if (seen_stall) begin
          state_next     = SB_DRAIN;
          load_done_next = 1'b1;
        end
      end

      default: state_next = SB_DRAIN;
    endcase
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
//   Directed testbench for store_buffer with a small data_mem model that
//   accepts one write per cycle and stalls one cycle on every read.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  store_buffer_if cpu_bus ();
  store_buffer_if mem_bus ();

  store_buffer #(
    .DEPTH (4),
    .PTR_W (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cpu   (cpu_bus),
    .mem   (mem_bus)
  );

  // data_mem model: write log, LED register, one-cycle read stall.
  logic        force_stall = 1'b0;
  logic        stall_q     = 1'b0;
  logic [31:0] rd_addr_q   = '0;
  logic [31:0] read_data_q = '0;
  logic [31:0] led         = '0;
  logic [31:0] dmem [0:1023];
  int          cyc      = 0;
  int          wr_count = 0;
  int          rd_count = 0;
  logic [31:0] wr_addr_log [0:63];
  logic [31:0] wr_data_log [0:63];
  int          wr_cyc_log  [0:63];
  int          rd_cyc_log  [0:63];

  assign mem_bus.stall     = stall_q | force_stall;
  assign mem_bus.read_data = read_data_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_bus.memwrite) begin
      if (wr_count < 64) begin
        wr_addr_log[wr_count] <= mem_bus.addr;
        wr_data_log[wr_count] <= mem_bus.write_data;
        wr_cyc_log[wr_count]  <= cyc;
      end
      wr_count <= wr_count + 1;
      if (mem_bus.addr == LED_ADDR) led <= mem_bus.write_data;
      else dmem[mem_bus.addr[11:2]] <= mem_bus.write_data;
    end
    if (mem_bus.memread) begin
      stall_q   <= 1'b1;
      rd_addr_q <= mem_bus.addr;
      if (rd_count < 64) rd_cyc_log[rd_count] <= cyc;
      rd_count <= rd_count + 1;
    end else if (stall_q) begin
      stall_q     <= 1'b0;
      read_data_q <= dmem[rd_addr_q[11:2]];
    end
  end

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] sm);
    @(negedge clk);
    cpu_bus.memwrite   = wr;
    cpu_bus.memread    = rd;
    cpu_bus.addr       = addr;
    cpu_bus.write_data = data;
    cpu_bus.sign_mask  = sm;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, SM_BYTE);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_mismatched=%0d", n_mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int rbase;
    int c0;
    int lat;
    int rd_high;
    logic done;

    cpu_bus.memwrite   = 1'b0;
    cpu_bus.memread    = 1'b0;
    cpu_bus.addr       = '0;
    cpu_bus.write_data = '0;
    cpu_bus.sign_mask  = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_memwrite", 32'(mem_bus.memwrite), 0);
    checkOutput("rst_memread", 32'(mem_bus.memread), 0);
    checkOutput("rst_addr", mem_bus.addr, 0);
    checkOutput("rst_wdata", mem_bus.write_data, 0);
    checkOutput("rst_sm", 32'(mem_bus.sign_mask), 0);
    checkOutput("rst_stall", 32'(cpu_bus.stall), 0);
    reset = 1'b0;

    // Four back-to-back stores drain one per cycle, in order.
    $display("[TB] back-to-back stores");
    base = wr_count;
    c0   = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), SM_WORD);
      if (k == 0) c0 = cyc;
      checkOutput($sformatf("burst_stall%0d", k), 32'(cpu_bus.stall), 0);
    end
    repeat (7) idle();
    checkOutput("burst_count", 32'(wr_count - base), 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("burst_addr%0d", k), wr_addr_log[base + k], 32'h100 + 32'(4 * k));
      checkOutput($sformatf("burst_data%0d", k), wr_data_log[base + k], 32'hA0 + 32'(k));
      checkOutput($sformatf("burst_cyc%0d", k), 32'(wr_cyc_log[base + k]), 32'(c0 + 2 + k));
    end

    // Reset with three entries queued discards them.
    $display("[TB] reset with queued stores");
    force_stall = 1'b1;
    base = wr_count;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h400 + 32'(4 * k), 32'hC0 + 32'(k), SM_WORD);
      checkOutput($sformatf("prerst_stall%0d", k), 32'(cpu_bus.stall), 0);
    end
    idle();
    checkOutput("prerst_count", 32'(dut.u_fifo.count), 3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("arst_count", 32'(dut.u_fifo.count), 0);
    checkOutput("arst_memwrite", 32'(mem_bus.memwrite), 0);
    checkOutput("arst_memread", 32'(mem_bus.memread), 0);
    checkOutput("arst_addr", mem_bus.addr, 0);
    checkOutput("arst_wdata", mem_bus.write_data, 0);
    checkOutput("arst_sm", 32'(mem_bus.sign_mask), 0);
    checkOutput("arst_stall", 32'(cpu_bus.stall), 0);
    @(negedge clk);
    reset       = 1'b0;
    force_stall = 1'b0;
    repeat (6) idle();
    checkOutput("arst_no_write", 32'(wr_count - base), 0);

    // Fill with drain blocked; fifth store stalls until the first pop.
    $display("[TB] full buffer");
    force_stall = 1'b1;
    base = wr_count;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h300 + 32'(4 * k), 32'hB0 + 32'(k), SM_WORD);
      checkOutput($sformatf("fill_stall%0d", k), 32'(cpu_bus.stall), (k == 4) ? 1 : 0);
    end
    @(negedge clk);
    force_stall = 1'b0;
    #1;
    checkOutput("full_pop_push_stall", 32'(cpu_bus.stall), 0);
    repeat (8) idle();
    checkOutput("full_count", 32'(wr_count - base), 5);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("full_addr%0d", k), wr_addr_log[base + k], 32'h300 + 32'(4 * k));
      checkOutput($sformatf("full_data%0d", k), wr_data_log[base + k], 32'hB0 + 32'(k));
    end

    // Load right after a store to the same address waits for the write.
    $display("[TB] load after store");
    base  = wr_count;
    rbase = rd_count;
    applyStimulus(1'b1, 1'b0, 32'h200, 32'hDEADBEEF, SM_WORD);
    checkOutput("st_stall", 32'(cpu_bus.stall), 0);
    applyStimulus(1'b0, 1'b1, 32'h200, 32'h0, SM_WORD);
    checkOutput("ld_st_stall", 32'(cpu_bus.stall), 1);
    lat  = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      #1;
      lat++;
      if (!cpu_bus.stall) done = 1'b1;
    end
    checkOutput("ld_st_done", 32'(done), 1);
    checkOutput("ld_st_latency", 32'(lat), 6);
    checkOutput("ld_st_rdata", cpu_bus.read_data, 32'hDEADBEEF);
    checkOutput("ld_st_writes", 32'(wr_count - base), 1);
    checkOutput("ld_st_reads", 32'(rd_count - rbase), 1);
    checkOutput("ld_st_order", 32'(rd_cyc_log[rbase] > wr_cyc_log[base]), 1);
    repeat (2) idle();

    // Load with an empty buffer: four-cycle latency, one-cycle memread.
    $display("[TB] load with empty buffer");
    rbase = rd_count;
    applyStimulus(1'b0, 1'b1, 32'h104, 32'h0, SM_WORD);
    checkOutput("ld_stall", 32'(cpu_bus.stall), 1);
    lat     = 0;
    rd_high = 0;
    done    = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      #1;
      lat++;
      if (mem_bus.memread) rd_high++;
      if (!cpu_bus.stall) done = 1'b1;
    end
    checkOutput("ld_done", 32'(done), 1);
    checkOutput("ld_latency", 32'(lat), 4);
    checkOutput("ld_memread_cycles", 32'(rd_high), 1);
    checkOutput("ld_reads", 32'(rd_count - rbase), 1);
    checkOutput("ld_rdata", cpu_bus.read_data, 32'hA1);
    repeat (2) idle();

    // LED store is buffered and reaches data_mem one drain cycle later.
    $display("[TB] LED store");
    applyStimulus(1'b1, 1'b0, LED_ADDR, 32'h1, SM_WORD);
    checkOutput("led_stall", 32'(cpu_bus.stall), 0);
    idle();
    checkOutput("led_c1_memwrite", 32'(mem_bus.memwrite), 0);
    checkOutput("led_before", led, 0);
    idle();
    checkOutput("led_c2_memwrite", 32'(mem_bus.memwrite), 1);
    checkOutput("led_c2_addr", mem_bus.addr, LED_ADDR);
    checkOutput("led_c2_wdata", mem_bus.write_data, 32'h1);
    idle();
    checkOutput("led_after", led, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the processor memory stage and data_mem. It absorbs stores into a small FIFO so the core does not wait on them.
- Drains buffered stores to data_mem one per cycle whenever data_mem is not servicing a load.
- Loads are held until the buffer is empty, so loads see program order; loads are never forwarded from the buffer.
- Presents the same request interface upstream that data_mem presents, plus a stall output.

Parameters:
- DEPTH, 4, number of store entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cpu_addr  input  32  byte address from the core.
- cpu_write_data  input  32  store data.
- cpu_memwrite  input  1  store request.
- cpu_memread  input  1  load request; never asserted together with cpu_memwrite.
- cpu_sign_mask  input  4  access size/sign code, passed through unchanged.
- cpu_stall  output  1  high means the core must hold its request stable.
- cpu_read_data  output  32  load result; wire from mem_read_data.
- mem_addr  output  32  to data_mem addr.
- mem_write_data  output  32  to data_mem write_data.
- mem_memwrite  output  1  to data_mem memwrite.
- mem_memread  output  1  to data_mem memread.
- mem_sign_mask  output  4  to data_mem sign_mask.
- mem_clk_stall  input  1  from data_mem clk_stall.

Behaviour:
- Reset (async, active-high):
  - FIFO pointers and count = 0.
  - State = DRAIN.
  - mem_memwrite = 0, mem_memread = 0, mem_addr = 0, mem_write_data = 0, mem_sign_mask = 0.
  - cpu_stall = 0.
  - Entries already in the buffer are discarded. A data_mem access in flight when reset asserts is abandoned.
- All mem_* outputs are registered. cpu_stall is combinational from state, count and the cpu request.
- Entry contents: {addr[31:0], data[31:0], sign_mask[3:0]}.
- States:
  - DRAIN (normal operation).
  - LOAD_ISSUE: mem_memread registered high for exactly 1 cycle.
  - LOAD_WAIT: waiting for data_mem to return the read.
- DRAIN, store handling:
  - cpu_memwrite with count<DEPTH: entry pushed at the clock edge; cpu_stall=0.
  - cpu_memwrite with count==DEPTH: cpu_stall=1 unless a pop occurs in the same cycle. With a simultaneous pop, the push is accepted and count is unchanged.
- DRAIN, draining:
  - Each cycle with count>0 and mem_clk_stall=0: the head entry is driven onto mem_* with mem_memwrite=1 next cycle, and the entry is popped.
  - Back-to-back drains are allowed, 1 per cycle, matching data_mem's write acceptance.
- DRAIN, load handling:
  - cpu_memread with count>0, or with a write issued in the current cycle: cpu_stall=1 and the buffer keeps draining.
  - cpu_memread with count==0 and no write in flight: register mem_addr, mem_sign_mask and mem_memread=1; go to LOAD_ISSUE; cpu_stall=1.
- LOAD_ISSUE:
  - mem_memread returns to 0 on the next edge; go to LOAD_WAIT; cpu_stall=1.
- LOAD_WAIT:
  - cpu_stall=1 while mem_clk_stall=1.
  - First cycle with mem_clk_stall=0 after it was seen high: cpu_read_data is valid. Deassert cpu_stall the following cycle and return to DRAIN.
  - Total load latency is 4 cycles from request to cpu_stall low when the buffer is empty.
- Ordering: stores reach data_mem in FIFO order. A load is never issued while any older store is pending.
- Stores to 0x2000 (LED) are buffered like any other store. The LED updates when the entry drains, not when the core issues it.
- Pointer wrap: modulo DEPTH. Full is count==DEPTH and empty is count==0; no pointer-compare ambiguity.
- Simultaneous push and pop:
  - When empty: the entry is pushed; the pop is not possible that cycle.
  - When full: the push is accepted per the DRAIN store rule above.
- cpu_memread and cpu_memwrite both high is illegal. Behaviour is undefined, but the block must not corrupt the FIFO: the store takes precedence.

Decomposition:
- Shared package, already used by the memory path:
  - sign_mask encodings (SM_BYTE, SM_HALF, SM_WORD, SM_SIGNED bit).
  - LED_ADDR = 32'h2000.
  - State encodings SB_DRAIN, SB_LOAD_ISSUE, SB_LOAD_WAIT.
- One sub-module: sb_fifo.
  - Parameterised synchronous FIFO, width 68, depth DEPTH.
  - push/pop/full/empty/count, async reset.
  - Instantiated once; the FSM and mem_* registers stay in store_buffer.

Test Plan:
- Reset while count=3 → count=0, all mem_* = 0, cpu_stall=0 on the same cycle; no write appears on mem_memwrite afterwards.
- 4 stores back-to-back (0x100..0x10C, data 0xA0..0xA3), mem_clk_stall=0 → cpu_stall stays 0; mem_memwrite is high for 4 consecutive cycles with addresses in order, starting 1 cycle after the first push.
- Force no drain (mem_clk_stall=1), push 5 stores → cpu_stall=1 on the 5th. Release → 5th accepted on the first pop cycle; all 5 reach memory in order.
- Store 0x200=0xDEADBEEF, then load 0x200 on the next cycle → cpu_stall held until the write has issued. mem_memread is high only after the last mem_memwrite; cpu_read_data=0xDEADBEEF.
- Load with empty buffer, data_mem model stalling 1 cycle → mem_memread high for 1 cycle; cpu_stall low exactly 4 cycles after the request.
- Store 0x2000=0x01 → mem_addr=0x2000 with mem_memwrite=1 appears one drain cycle later, and the data_mem LED updates.
